seq_digit_mult: RTL
===================

Name: seq_digit_mult

Overview:
Parametrised, iterative unsigned WIDTH x WIDTH multiplier built from 2x2 base-digit multipliers.
- Each RUN cycle multiplies all of A by one 2-bit digit of B, using WIDTH/2 base multipliers, and shift-accumulates the row.
- valid/ready handshakes on input and output.
- Successor to the fixed 4-bit four-instance combinational multipliers; it is the scalable, pipelinable datapath element for 8/16/32-bit experiments.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4. NDIG = WIDTH/2 digits.
- ACC_W, 2*WIDTH, accumulator and product width; fixed by WIDTH, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands offered
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product p valid
- out_ready  input  1  consumer accepts product
- p  output  2*WIDTH  product a*b
- busy  output  1  state != IDLE

Behaviour:
- One clock (clk); reset asynchronous active-low (rst_n). While rst_n low: state=IDLE, out_valid=0, p=0, busy=0, digit index k=0, operand regs=0. in_ready decodes IDLE, so it is 1 once in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a->a_reg and b->b_reg, clear acc, set k=0, go to RUN. Operands are sampled only at this handshake.
- RUN: in_ready=0; in_valid is ignored.
  - Per edge: row = sum over i of base(a_reg[2i+1:2i], b_reg[2k+1:2k]) << 2i, computed at WIDTH+2 bits, no truncation.
  - acc <= acc + (row << 2k), at 2*WIDTH bits; overflow is impossible.
  - k <= k+1. On the edge processing k==NDIG-1, go to DONE.
- Latency: out_valid rises NDIG edges after the accepting edge (4 for WIDTH=8).
- DONE: out_valid=1, p=acc.
  - p and out_valid are held stable while out_ready=0; backpressure is unbounded.
  - On out_ready=1, go to IDLE with out_valid=0 on the next edge.
- Throughput: one operation per NDIG+2 cycles. There is no combinational ready path: in_ready does not depend on out_ready.
- p holds its last value in IDLE. It changes only during RUN and on reset.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No partial result is emitted.
- Zero operands take the normal path; result 0 with full latency unless the optional feature is enabled.

Optional Feature:
SEQ_MULT_EARLY_TERM_EN
- Defined: on each RUN edge, if b_reg digits above k are all zero, go to DONE after that edge's accumulate. Latency becomes max(1, index of highest nonzero B digit + 1); b=0 takes 1 cycle.
- Undefined: latency is fixed at NDIG for all operands. No extra comparator logic is synthesised.
- The result value is identical in both builds.

Decomposition:
- Package seq_mult_pkg:
  - DIGIT_W=2 constant
  - state enum typedef {IDLE, RUN, DONE}
  - function ndig(width)
  - localparam check that WIDTH is even and >= 4
- Sub-module mult2x2_base: combinational 2-bit x 2-bit -> 4-bit product, instantiated NDIG times in a generate loop.
- Row adder tree and FSM stay in seq_digit_mult.

Test Plan:
- WIDTH=8, a=255, b=255, out_ready=1 -> p=0xFE01 (65025), out_valid high exactly 4 edges after accept, in_ready low for 5 cycles.
- WIDTH=8, a=200, b=3 -> p=600. Latency 1 with SEQ_MULT_EARLY_TERM_EN, 4 without. Also b=0 -> p=0, latency 1 / 4 respectively.
- Backpressure: a=13, b=11, out_ready held 0 for 6 cycles -> p=143 and out_valid stable throughout. in_valid pulses in that window are not accepted. Product drops one edge after out_ready=1.
- Reset mid-RUN: a=0xAB, b=0xCD, drop rst_n at cycle 2 -> out_valid=0, p=0, busy=0 immediately. Next op a=7, b=9 -> p=63 with normal latency.
- Back-to-back: 4 ops with in_valid held high and out_ready=1 -> each accepted only in IDLE, products in order, NDIG+2 cycle spacing.
- Parameter sweep WIDTH=4, 16, 32: 1000 random operand pairs plus all-ones/one-hot corners vs golden a*b, zero mismatches, latency = NDIG.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared constants, state type and elaboration helpers for the iterative
// digit-serial multiplier.
package seq_mult_pkg;

  // Base digit width: the multiplier consumes B two bits per RUN cycle.
  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of base digits in an operand of the given width.
  function automatic int unsigned ndig(input int unsigned width);
    return width / DIGIT_W;
  endfunction

  // Operand width must split into whole digits and give at least two of them.
  function automatic bit width_ok(input int unsigned width);
    return ((width % DIGIT_W) == 0) && (width >= 4);
  endfunction

endpackage

// File: rtl/mult2x2_base.sv
// Combinational 2-bit x 2-bit unsigned base multiplier (4-bit product).
module mult2x2_base (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  // Two partial products, the upper one shifted by one bit.
  assign o_p = ({2'b00, i_a & {2{i_b[0]}}}) + ({1'b0, i_a & {2{i_b[1]}}, 1'b0});

endmodule

// File: rtl/seq_digit_mult.sv
// Iterative unsigned WIDTH x WIDTH multiplier. Each RUN cycle multiplies all of
// A by one 2-bit digit of B using WIDTH/2 base multipliers and shift-accumulates
// the resulting row. valid/ready handshakes on both sides.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining
// B digits are all zero (result is unchanged, only latency shrinks).
module seq_digit_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned NDIG  = ndig(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned ROW_W = WIDTH + DIGIT_W;
  localparam int unsigned K_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NDIG - 1);
  localparam bit WIDTH_OK = width_ok(WIDTH);

  if (!WIDTH_OK) begin : g_bad_width
    $error("seq_digit_mult: WIDTH must be even and >= 4");
  end

  state_e            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [ACC_W-1:0]  r_acc;
  logic [K_W-1:0]    r_k;
  logic              r_out_valid;

  logic [DIGIT_W-1:0]   w_bdig;
  logic [2*DIGIT_W-1:0] w_pp [NDIG];
  logic [ROW_W-1:0]     w_row;
  logic [ACC_W-1:0]     w_acc_next;
  logic                 w_last;

  assign w_bdig = r_b[DIGIT_W*r_k +: DIGIT_W];

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_base
    mult2x2_base u_base (
      .i_a (r_a[DIGIT_W*gi +: DIGIT_W]),
      .i_b (w_bdig),
      .o_p (w_pp[gi])
    );
  end

  // Sum the digit products into one row; ROW_W bits hold 3*(2^WIDTH-1) exactly.
  always_comb begin
    w_row = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_row = w_row + (ROW_W'(w_pp[i]) << (DIGIT_W * i));
    end
  end

  // The first RUN cycle starts from zero instead of clearing the accumulator at
  // accept, so p keeps the previous product through IDLE.
  assign w_acc_next = ((r_k == '0) ? '0 : r_acc) + (ACC_W'(w_row) << (DIGIT_W * r_k));

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] w_b_hi;
  assign w_b_hi = r_b >> (DIGIT_W * (32'(r_k) + 32'd1));
  assign w_last = (r_k == K_LAST) || (w_b_hi == '0);
`else
  assign w_last = (r_k == K_LAST);
`endif

  // Control FSM with registered datapath and output-valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_k     <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign out_valid = r_out_valid;
  assign p         = r_acc;

endmodule
